// File: rtl/alu_cmd_framer_if.sv
// Byte-stream input, command handshake and error reporting bus of the ALU command framer.
// The framer attaches through the slave modport; the byte source / command sink uses master.
interface alu_cmd_framer_if;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               cmd_ready;
    logic               cmd_valid;
    logic signed [15:0] alu_A;
    logic signed [15:0] alu_B;
    logic [2:0]         alu_op;
    logic               err_checksum;
    logic               err_format;
    logic               err_timeout;
    logic               err_overrun;
    logic [7:0]         err_count;

    modport slave (
        input  rx_valid, rx_data, cmd_ready,
        output cmd_valid, alu_A, alu_B, alu_op,
        output err_checksum, err_format, err_timeout, err_overrun, err_count
    );

    modport master (
        output rx_valid, rx_data, cmd_ready,
        input  cmd_valid, alu_A, alu_B, alu_op,
        input  err_checksum, err_format, err_timeout, err_overrun, err_count
    );
endinterface

// File: rtl/alu_cmd_framer.sv
// Hunts for SYNC, assembles a 7-byte command frame, checks opcode and XOR checksum,
// and holds the decoded ALU command under a valid/ready handshake.
module alu_cmd_framer #(
    parameter int unsigned IDLE_TIMEOUT = 54250,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_framer_if.slave   bus
);
    localparam int unsigned GAP_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_TERM = GAP_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OP, S_AH, S_AL, S_BH, S_BL, S_CHK, S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [GAP_W-1:0]   r_gap;
    logic [7:0]         r_xor;
    logic [2:0]         r_op_sh;
    logic [15:0]        r_a_sh;
    logic [15:0]        r_b_sh;

    logic               r_cmd_valid;
    logic signed [15:0] r_alu_a;
    logic signed [15:0] r_alu_b;
    logic [2:0]         r_alu_op;
    logic               r_err_checksum;
    logic               r_err_format;
    logic               r_err_timeout;
    logic               r_err_overrun;
    logic [7:0]         r_err_count;

    logic               w_in_frame;
    logic               w_gap_term;
    logic               w_chk_ok;
    logic               w_err_checksum;
    logic               w_err_format;
    logic               w_err_timeout;
    logic               w_err_overrun;
    logic               w_any_err;
    logic               w_load;

    assign w_in_frame = (r_state == S_OP) || (r_state == S_AH) || (r_state == S_AL) ||
                        (r_state == S_BH) || (r_state == S_BL) || (r_state == S_CHK);
    assign w_gap_term = (r_gap == GAP_TERM);
    assign w_chk_ok   = (r_xor == bus.rx_data);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; a byte always wins over the gap terminal count
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) w_state_nxt = S_OP;
            S_OP: begin
                if (bus.rx_valid)  w_state_nxt = (bus.rx_data[7:3] != 5'd0) ? S_IDLE : S_AH;
                else if (w_gap_term) w_state_nxt = S_IDLE;
            end
            S_AH: begin
                if (bus.rx_valid)    w_state_nxt = S_AL;
                else if (w_gap_term) w_state_nxt = S_IDLE;
            end
            S_AL: begin
                if (bus.rx_valid)    w_state_nxt = S_BH;
                else if (w_gap_term) w_state_nxt = S_IDLE;
            end
            S_BH: begin
                if (bus.rx_valid)    w_state_nxt = S_BL;
                else if (w_gap_term) w_state_nxt = S_IDLE;
            end
            S_BL: begin
                if (bus.rx_valid)    w_state_nxt = S_CHK;
                else if (w_gap_term) w_state_nxt = S_IDLE;
            end
            S_CHK: begin
                if (bus.rx_valid)    w_state_nxt = w_chk_ok ? S_HOLD : S_IDLE;
                else if (w_gap_term) w_state_nxt = S_IDLE;
            end
            S_HOLD: if (r_cmd_valid && bus.cmd_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered pulses and the command load
    always_comb begin
        w_err_format   = 1'b0;
        w_err_checksum = 1'b0;
        w_err_timeout  = 1'b0;
        w_err_overrun  = 1'b0;
        w_load         = 1'b0;
        if (r_state == S_OP && bus.rx_valid && (bus.rx_data[7:3] != 5'd0))
            w_err_format = 1'b1;
        if (r_state == S_CHK && bus.rx_valid) begin
            w_err_checksum = !w_chk_ok;
            w_load         = w_chk_ok;
        end
        if (w_in_frame && !bus.rx_valid && w_gap_term)
            w_err_timeout = 1'b1;
        if (r_state == S_HOLD && bus.rx_valid)
            w_err_overrun = 1'b1;
        w_any_err = w_err_format | w_err_checksum | w_err_timeout | w_err_overrun;
    end

    // Frame datapath: gap counter, running checksum and shadow operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap   <= '0;
            r_xor   <= 8'd0;
            r_op_sh <= 3'd0;
            r_a_sh  <= 16'd0;
            r_b_sh  <= 16'd0;
        end else begin
            if (w_in_frame && !bus.rx_valid && !w_gap_term) r_gap <= r_gap + GAP_W'(1);
            else                                            r_gap <= '0;
            if (bus.rx_valid) begin
                unique case (r_state)
                    S_OP: begin
                        r_xor   <= bus.rx_data;
                        r_op_sh <= bus.rx_data[2:0];
                    end
                    S_AH: begin
                        r_xor         <= r_xor ^ bus.rx_data;
                        r_a_sh[15:8]  <= bus.rx_data;
                    end
                    S_AL: begin
                        r_xor         <= r_xor ^ bus.rx_data;
                        r_a_sh[7:0]   <= bus.rx_data;
                    end
                    S_BH: begin
                        r_xor         <= r_xor ^ bus.rx_data;
                        r_b_sh[15:8]  <= bus.rx_data;
                    end
                    S_BL: begin
                        r_xor         <= r_xor ^ bus.rx_data;
                        r_b_sh[7:0]   <= bus.rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_valid    <= 1'b0;
            r_alu_a        <= 16'sd0;
            r_alu_b        <= 16'sd0;
            r_alu_op       <= 3'd0;
            r_err_checksum <= 1'b0;
            r_err_format   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
            r_err_count    <= 8'd0;
        end else begin
            r_cmd_valid    <= (w_state_nxt == S_HOLD);
            r_err_checksum <= w_err_checksum;
            r_err_format   <= w_err_format;
            r_err_timeout  <= w_err_timeout;
            r_err_overrun  <= w_err_overrun;
            if (w_load) begin
                r_alu_a  <= $signed(r_a_sh);
                r_alu_b  <= $signed(r_b_sh);
                r_alu_op <= r_op_sh;
            end
            if (w_any_err && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.alu_A        = r_alu_a;
    assign bus.alu_B        = r_alu_b;
    assign bus.alu_op       = r_alu_op;
    assign bus.err_checksum = r_err_checksum;
    assign bus.err_format   = r_err_format;
    assign bus.err_timeout  = r_err_timeout;
    assign bus.err_overrun  = r_err_overrun;
    assign bus.err_count    = r_err_count;
endmodule

// File: tb/tb_alu_cmd_framer.sv
// Directed bench for alu_cmd_framer: frames, error cases, timeout edge, overrun, reset, saturation.
module tb_alu_cmd_framer;
    localparam int unsigned TO = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_cmd_framer_if bus ();

    alu_cmd_framer #(.IDLE_TIMEOUT(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; byte is sampled on the next rising edge, returns at the falling edge after it
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] ah, input logic [7:0] al,
                              input logic [7:0] bh, input logic [7:0] bl, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(ah);
        send_byte(al);
        send_byte(bh);
        send_byte(bl);
        send_byte(chk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.cmd_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        check("rst_cmd_valid", 16'(bus.cmd_valid), 16'd0);
        check("rst_alu_A",     bus.alu_A,          16'h0000);
        check("rst_alu_B",     bus.alu_B,          16'h0000);
        check("rst_alu_op",    16'(bus.alu_op),    16'd0);
        check("rst_err_count", 16'(bus.err_count), 16'd0);

        // Valid frame, ready already high: one-cycle cmd_valid
        bus.cmd_ready = 1'b1;
        send_frame(8'h03, 8'h00, 8'h05, 8'hFF, 8'hFE, 8'h07);
        check("f1_valid", 16'(bus.cmd_valid), 16'd1);
        check("f1_op",    16'(bus.alu_op),    16'd3);
        check("f1_A",     bus.alu_A,          16'h0005);
        check("f1_B",     bus.alu_B,          16'hFFFE);
        check("f1_errs",  16'(bus.err_count), 16'd0);
        tick(1);
        check("f1_valid_drop", 16'(bus.cmd_valid), 16'd0);

        // Bad checksum
        send_frame(8'h03, 8'h00, 8'h05, 8'hFF, 8'hFE, 8'h08);
        check("chk_pulse", 16'(bus.err_checksum), 16'd1);
        check("chk_valid", 16'(bus.cmd_valid),    16'd0);
        check("chk_count", 16'(bus.err_count),    16'd1);
        check("chk_A",     bus.alu_A,             16'h0005);
        check("chk_B",     bus.alu_B,             16'hFFFE);
        tick(1);
        check("chk_pulse_end", 16'(bus.err_checksum), 16'd0);

        // Junk bytes, then bad opcode, then a good frame
        send_byte(8'h11);
        send_byte(8'h22);
        check("junk_count", 16'(bus.err_count), 16'd1);
        send_byte(8'hA5);
        send_byte(8'h0A);
        check("fmt_pulse", 16'(bus.err_format), 16'd1);
        check("fmt_count", 16'(bus.err_count),  16'd2);
        send_frame(8'h05, 8'h12, 8'h34, 8'h00, 8'h07, 8'h24);
        check("f2_valid", 16'(bus.cmd_valid), 16'd1);
        check("f2_op",    16'(bus.alu_op),    16'd5);
        check("f2_A",     bus.alu_A,          16'h1234);
        check("f2_B",     bus.alu_B,          16'h0007);
        tick(1);

        // Inter-byte gap reaching the terminal count
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        tick(TO - 1);
        check("to_early", 16'(bus.err_timeout), 16'd0);
        tick(1);
        check("to_pulse", 16'(bus.err_timeout), 16'd1);
        check("to_count", 16'(bus.err_count),   16'd3);
        tick(1);

        // Byte on the terminal count is accepted
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        tick(TO - 1);
        send_byte(8'h05);
        check("term_no_to", 16'(bus.err_timeout), 16'd0);
        send_byte(8'hFF);
        send_byte(8'hFE);
        send_byte(8'h05);
        check("term_valid", 16'(bus.cmd_valid), 16'd1);
        check("term_op",    16'(bus.alu_op),    16'd1);
        check("term_A",     bus.alu_A,          16'h0005);
        check("term_count", 16'(bus.err_count), 16'd3);
        tick(1);

        // Overrun while holding
        bus.cmd_ready = 1'b0;
        send_frame(8'h06, 8'h00, 8'h0A, 8'h00, 8'h03, 8'h0F);
        check("h_valid", 16'(bus.cmd_valid), 16'd1);
        check("h_op",    16'(bus.alu_op),    16'd6);
        tick(2);
        check("h_still", 16'(bus.cmd_valid), 16'd1);
        send_byte(8'h5C);
        check("ov_pulse", 16'(bus.err_overrun), 16'd1);
        check("ov_valid", 16'(bus.cmd_valid),   16'd1);
        check("ov_A",     bus.alu_A,            16'h000A);
        check("ov_B",     bus.alu_B,            16'h0003);
        check("ov_count", 16'(bus.err_count),   16'd4);
        tick(1);
        check("ov_pulse_end", 16'(bus.err_overrun), 16'd0);
        bus.cmd_ready = 1'b1;
        tick(1);
        check("h_release", 16'(bus.cmd_valid), 16'd0);

        // Overrun on the handshake cycle itself
        bus.cmd_ready = 1'b0;
        send_frame(8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03);
        check("h2_valid", 16'(bus.cmd_valid), 16'd1);
        bus.cmd_ready = 1'b1;
        send_byte(8'h5C);
        check("ovh_pulse", 16'(bus.err_overrun), 16'd1);
        check("ovh_valid", 16'(bus.cmd_valid),   16'd0);
        check("ovh_count", 16'(bus.err_count),   16'd5);
        tick(1);

        // Reset mid-frame discards everything
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_valid", 16'(bus.cmd_valid), 16'd0);
        check("mrst_count", 16'(bus.err_count), 16'd0);
        check("mrst_A",     bus.alu_A,          16'h0000);
        send_frame(8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h05);
        check("f3_valid", 16'(bus.cmd_valid), 16'd1);
        check("f3_op",    16'(bus.alu_op),    16'd2);
        check("f3_A",     bus.alu_A,          16'h0003);
        check("f3_B",     bus.alu_B,          16'h0004);
        tick(1);

        // Error counter saturation
        for (int i = 0; i < 255; i++) begin
            send_byte(8'hA5);
            send_byte(8'h08);
        end
        check("sat_255", 16'(bus.err_count), 16'd255);
        send_byte(8'hA5);
        send_byte(8'h08);
        check("sat_pulse", 16'(bus.err_format), 16'd1);
        check("sat_hold",  16'(bus.err_count),  16'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
